// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the length clamp applied to every counter load.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } ps_state_t;

    // max(len,1)-1: a zero length still yields a single high cycle
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len == '0) ? '0 : len - 32'd1;
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag; decrement saturates at zero so the
// count never wraps.
module load_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into high levels of programmable length,
// each followed by a guaranteed low gap; one strobe can be queued.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int RETRIGGER  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inpulse,
    input  logic [CNT_W-1:0] len,
    output logic             levelout,
    output logic             busy,
    output logic             dropped
);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    ps_state_t        state, next_state;
    logic             pending, next_pending;
    logic [CNT_W-1:0] pending_len, next_plen;
    logic             cnt_load, cnt_dec, cnt_zero, drop;
    logic [CNT_W-1:0] cnt_val;

    load_down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_comb begin
        next_state   = state;
        next_pending = pending;
        next_plen    = pending_len;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;
        drop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (inpulse) begin
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(clamp_len(32'(len)));
                    next_state = S_HIGH;
                end
            end
            S_HIGH: begin
                if (inpulse && (RETRIGGER != 0)) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(clamp_len(32'(len)));
                end else begin
                    if (cnt_zero) begin
                        cnt_load   = 1'b1;
                        cnt_val    = GAP_LOAD;
                        next_state = S_GAP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                    if (inpulse) begin
                        if (!pending) begin
                            next_pending = 1'b1;
                            next_plen    = len;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    // A strobe arriving as the queue drains refills it rather than being dropped
                    if (pending) begin
                        cnt_load     = 1'b1;
                        cnt_val      = CNT_W'(clamp_len(32'(pending_len)));
                        next_state   = S_HIGH;
                        next_pending = inpulse;
                        if (inpulse) begin
                            next_plen = len;
                        end
                    end else if (inpulse) begin
                        cnt_load   = 1'b1;
                        cnt_val    = CNT_W'(clamp_len(32'(len)));
                        next_state = S_HIGH;
                    end else begin
                        next_state = S_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                    if (inpulse) begin
                        if (!pending) begin
                            next_pending = 1'b1;
                            next_plen    = len;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            pending_len <= '0;
            levelout    <= 1'b0;
            busy        <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            state       <= next_state;
            pending     <= next_pending;
            pending_len <= next_plen;
            levelout    <= (next_state == S_HIGH);
            busy        <= (next_state != S_IDLE) || next_pending;
            dropped     <= drop;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: queued and retriggering variants share one stimulus stream;
// per-cycle expected {levelout,busy,dropped} come from hand-derived timing tables.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       inpulse;
    logic [7:0] len;
    logic       lvl0, busy0, drp0;
    logic       lvl1, busy1, drp1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        int         dut;
        logic [2:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    pulse_stretcher #(
        .CNT_W     (8),
        .GAP_CYCLES(2),
        .RETRIGGER (0)
    ) dut0 (
        .clk     (clk),
        .rst     (rst),
        .inpulse (inpulse),
        .len     (len),
        .levelout(lvl0),
        .busy    (busy0),
        .dropped (drp0)
    );

    pulse_stretcher #(
        .CNT_W     (8),
        .GAP_CYCLES(2),
        .RETRIGGER (1)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .inpulse (inpulse),
        .len     (len),
        .levelout(lvl1),
        .busy    (busy1),
        .dropped (drp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got{lvl,busy,drp}=%b want=%b", tag, got, want);
        end
    endtask

    function automatic bit inr(input int n, input int a, input int b);
        return (n >= a) && (n <= b);
    endfunction

    function automatic bit strobe_at(input int t, input int n);
        case (t)
            1, 2:    return n == 10;
            3, 6:    return (n == 10) || (n == 12);
            4:       return (n >= 10) && (n <= 12);
            5:       return (n == 10) || (n == 13);
            7:       return (n == 10) || (n == 14);
            8:       return (n == 10) || (n == 11) || (n == 14);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int len_of(input int t);
        case (t)
            2:       return 0;
            3:       return 3;
            7, 8:    return 2;
            default: return 4;
        endcase
    endfunction

    // Expected {levelout, busy, dropped} observed at clock edge n
    function automatic logic [2:0] expv(input int t, input int d, input int n);
        bit l, b, p;
        l = 1'b0; b = 1'b0; p = 1'b0;
        case (t)
            1: begin l = inr(n, 11, 14); b = inr(n, 11, 16); end
            2: begin l = inr(n, 11, 11); b = inr(n, 11, 13); end
            3: if (d == 0) begin
                   l = inr(n, 11, 13) || inr(n, 16, 18); b = inr(n, 11, 20);
               end else begin
                   l = inr(n, 11, 15); b = inr(n, 11, 17);
               end
            4: if (d == 0) begin
                   l = inr(n, 11, 14) || inr(n, 17, 20); b = inr(n, 11, 22); p = (n == 13);
               end else begin
                   l = inr(n, 11, 16); b = inr(n, 11, 18);
               end
            5: if (d == 0) begin
                   l = inr(n, 11, 14) || inr(n, 17, 20); b = inr(n, 11, 22);
               end else begin
                   l = inr(n, 11, 17); b = inr(n, 11, 19);
               end
            6: begin l = inr(n, 11, 12); b = inr(n, 11, 12); end
            7: begin l = inr(n, 11, 12) || inr(n, 15, 16); b = inr(n, 11, 18); end
            8: if (d == 0) begin
                   l = inr(n, 11, 12) || inr(n, 15, 16) || inr(n, 19, 20); b = inr(n, 11, 22);
               end else begin
                   l = inr(n, 11, 13) || inr(n, 16, 17); b = inr(n, 11, 19);
               end
            default: ;
        endcase
        return {l, b, p};
    endfunction

    initial begin
        sb_entry_t  e;
        logic [2:0] got;
        rst     = 1'b1;
        inpulse = 1'b0;
        len     = '0;
        for (int t = 1; t <= 8; t++) begin
            for (int n = 3; n <= 25; n++) begin
                for (int d = 0; d < 2; d++) begin
                    e.cyc = n;
                    e.dut = d;
                    e.exp = expv(t, d, n);
                    sb_q.push_back(e);
                end
            end
            for (int n = 0; n <= 26; n++) begin
                @(negedge clk);
                while ((sb_q.size() > 0) && (sb_q[0].cyc == n)) begin
                    e   = sb_q.pop_front();
                    got = (e.dut == 0) ? {lvl0, busy0, drp0} : {lvl1, busy1, drp1};
                    check_eq($sformatf("t%0d_d%0d_c%0d", t, e.dut, n), got, e.exp);
                end
                rst     = (n <= 2) || ((t == 6) && (n == 12));
                inpulse = strobe_at(t, n);
                len     = 8'(len_of(t));
            end
            if (sb_q.size() != 0) begin
                check_eq($sformatf("t%0d_leftover", t), 3'b000, 3'b111);
                sb_q.delete();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
